delay_scheduler: RTL and testbench
==================================

DELAY_SCHEDULER -- requirements
Module: delay_scheduler

Interface
REQ-001 Parameter MaxCount, default 3, delay length in clock cycles (set to 10000 for board builds).
REQ-002 Parameter NumberOfBits, default 20, internal delay counter width; MaxCount SHALL be less than 2**NumberOfBits.
REQ-003 Clock  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 Reset  input  1  reset, synchronous, active-low (Reset==0 resets on the next rising Clock edge).
REQ-005 Request  input  4  level request per requester; bit i high means requester i wants one delay period.
REQ-006 Grant  output  4  one-hot registered grant; bit i high while requester i owns the delay timer.
REQ-007 GrantId  output  2  index of the current or most recent grantee.
REQ-008 Done  output  4  registered one-cycle completion pulse to the grantee.
REQ-009 Busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 The block SHALL contain one internal delay counter shared by four requesters; it SHALL contain no per-requester timers.
REQ-011 The FSM SHALL have states IDLE, RUN and DONE; no other states SHALL be reachable.
REQ-012 IDLE: if any Request bit is high, the FSM SHALL pick a winner, load GrantId, set Grant to the winner's bit, clear count to 0 and enter RUN on the same edge; otherwise it SHALL stay in IDLE.
REQ-013 Arbitration SHALL be round-robin: search order starts at pointer Ptr and proceeds Ptr, Ptr+1, ... modulo 4; the first high Request bit wins.
REQ-014 RUN: count SHALL increment by 1 per cycle; on the edge where count==MaxCount the FSM SHALL enter DONE, clear Grant and clear count.
REQ-015 Grant SHALL be high for exactly MaxCount+1 cycles per grant; MaxCount=0 gives a one-cycle grant.
REQ-016 DONE: Done[GrantId] SHALL be high for exactly this one cycle; Ptr SHALL become GrantId+1 modulo 4 (3 wraps to 0); the FSM SHALL return to IDLE on the next edge.
REQ-017 Latency: with Request sampled high in IDLE at edge k, Grant is high from cycle k+1 through k+1+MaxCount, Done is high in cycle k+2+MaxCount, and the earliest next grant begins at cycle k+4+MaxCount.
REQ-018 Request bits that change while the FSM is in RUN or DONE SHALL NOT change the winner; they are considered only in IDLE.
REQ-019 At most one Grant bit and at most one Done bit SHALL be high in any cycle, and Grant and Done SHALL never be high in the same cycle.
REQ-020 Count arithmetic SHALL be NumberOfBits wide and unsigned; count SHALL never exceed MaxCount.

Reset
REQ-021 When Reset==0 at a rising edge: state=IDLE, count=0, Ptr=0, Grant=0000, Done=0000, GrantId=00, Busy=0.
REQ-022 Reset SHALL override every other input, including in the middle of RUN or DONE; an interrupted grant SHALL produce no Done pulse.

Configuration
REQ-023 Macro DELAY_SCHED_ABORT_EN enables or disables abort.
REQ-024 With DELAY_SCHED_ABORT_EN defined: if Request[GrantId]==0 at a RUN edge, the FSM SHALL go to IDLE on that edge, clear Grant and count, emit no Done, and set Ptr=GrantId+1 modulo 4.
REQ-025 Without DELAY_SCHED_ABORT_EN: a dropped Request during RUN SHALL be ignored and the delay SHALL complete with a normal Done pulse.

Verification (MaxCount=3 unless stated; cycle 0 = first edge after Reset goes high)
REQ-026 Single request: Request=0001 from cycle 0 -> Grant=0001 in cycles 1-4, Done=0001 in cycle 5, Busy=1 in cycles 1-5, then IDLE.
REQ-027 Contention: Request=1111 held -> grants in order GrantId 0,1,2,3,0, each lasting 4 cycles, grant starts 6 cycles apart, one Done pulse per grant.
REQ-028 Wrap-around: after requester 3 is served, Request=1001 -> requester 0 wins (Ptr=0).
REQ-029 Reset mid-RUN: drive Reset=0 at count=2 with Grant=0100 -> next cycle Grant=0000, Busy=0, no Done; after Reset returns high, Request=1001 -> requester 0 wins.
REQ-030 Abort: Request[0] dropped at count=1 -> with DELAY_SCHED_ABORT_EN, Grant=0000 next cycle and no Done; without it, Done=0001 in cycle 5 as in REQ-026.
REQ-031 MaxCount=0: Request=0010 -> Grant=0010 for one cycle, Done=0010 in the following cycle.

Source files
------------

// File: rtl/delay_scheduler.sv
// delay_scheduler
//   One shared delay timer arbitrated round-robin among four requesters.
//   A winner holds Grant for MaxCount+1 cycles, then receives a one-cycle
//   Done pulse, after which the search pointer moves past it.
//
//   Parameters
//     MaxCount     : delay length in clock cycles (10000 for board builds)
//     NumberOfBits : delay counter width, MaxCount < 2**NumberOfBits
//
//   Ports
//     Clock   : single clock, rising edge
//     Reset   : synchronous, active-low
//     Request : level request per requester
//     Grant   : one-hot registered grant
//     GrantId : index of current / most recent grantee
//     Done    : registered one-cycle completion pulse to the grantee
//     Busy    : high whenever the FSM is not idle
//
//   Build option
//     DELAY_SCHED_ABORT_EN : when defined, dropping Request[GrantId] during
//                            the delay aborts the grant with no Done pulse.
module delay_scheduler #(
  parameter int unsigned MaxCount     = 3,
  parameter int unsigned NumberOfBits = 20
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Request,
  output logic [3:0] Grant,
  output logic [1:0] GrantId,
  output logic [3:0] Done,
  output logic       Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [NumberOfBits-1:0] CountEnd = NumberOfBits'(MaxCount);

  state_t                  state;
  state_t                  state_next;
  logic [NumberOfBits-1:0] count;
  logic [NumberOfBits-1:0] count_next;
  logic [1:0]              ptr;
  logic [1:0]              ptr_next;
  logic [3:0]              grant_next;
  logic [1:0]              id_next;
  logic [3:0]              done_next;

  logic [1:0]              winner;
  logic [1:0]              idx;
  logic                    found;
  logic                    drop;

  // Round-robin search: first high request starting at ptr, wrapping mod 4.
  always_comb begin
    winner = ptr;
    idx    = ptr;
    found  = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && Request[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

`ifdef DELAY_SCHED_ABORT_EN
  assign drop = ~Request[GrantId];
`else
  assign drop = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_next = state;
    count_next = count;
    ptr_next   = ptr;
    grant_next = Grant;
    id_next    = GrantId;
    done_next  = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_next = RUN;
          id_next    = winner;
          grant_next = 4'b0001 << winner;
          count_next = '0;
        end
      end
      RUN: begin
        if (drop) begin
          state_next = IDLE;
          grant_next = '0;
          count_next = '0;
          ptr_next   = GrantId + 2'd1;
        end else if (count == CountEnd) begin
          state_next = DONE;
          grant_next = '0;
          count_next = '0;
          done_next  = 4'b0001 << GrantId;
        end else begin
          count_next = count + NumberOfBits'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        ptr_next   = GrantId + 2'd1;
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state   <= IDLE;
      count   <= '0;
      ptr     <= '0;
      Grant   <= '0;
      GrantId <= '0;
      Done    <= '0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      ptr     <= ptr_next;
      Grant   <= grant_next;
      GrantId <= id_next;
      Done    <= done_next;
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_delay_scheduler.sv
// tb_delay_scheduler
//   Directed bench for delay_scheduler: one instance with MaxCount=3 and one
//   with MaxCount=0 sharing clock and reset.
module tb_delay_scheduler;

  localparam int MC = 3;

  logic       Clock;
  logic       Reset;
  logic [3:0] Request;
  logic [3:0] Grant;
  logic [1:0] GrantId;
  logic [3:0] Done;
  logic       Busy;

  logic [3:0] Request0;
  logic [3:0] Grant0;
  logic [1:0] GrantId0;
  logic [3:0] Done0;
  logic       Busy0;

  int n_cmp = 0;
  int n_err = 0;

  delay_scheduler #(.MaxCount(MC), .NumberOfBits(20)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Request (Request),
    .Grant   (Grant),
    .GrantId (GrantId),
    .Done    (Done),
    .Busy    (Busy)
  );

  delay_scheduler #(.MaxCount(0), .NumberOfBits(4)) dut0 (
    .Clock   (Clock),
    .Reset   (Reset),
    .Request (Request0),
    .Grant   (Grant0),
    .GrantId (GrantId0),
    .Done    (Done0),
    .Busy    (Busy0)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Called just after the edge that granted: checks the whole grant,
  // the Done pulse and the following idle cycle. Ends in the idle cycle.
  task automatic serve(input logic [3:0] g, input logic [1:0] id, input string tag);
    for (int c = 0; c <= MC; c++) begin
      check({tag, "_grant"}, 32'(Grant), 32'(g));
      check({tag, "_id"}, 32'(GrantId), 32'(id));
      check({tag, "_nodone"}, 32'(Done), 32'h0);
      check({tag, "_busy"}, 32'(Busy), 32'h1);
      tick();
    end
    check({tag, "_done"}, 32'(Done), 32'(g));
    check({tag, "_grant_off"}, 32'(Grant), 32'h0);
    check({tag, "_busy_done"}, 32'(Busy), 32'h1);
    tick();
    check({tag, "_idle_busy"}, 32'(Busy), 32'h0);
    check({tag, "_idle_done"}, 32'(Done), 32'h0);
    check({tag, "_idle_grant"}, 32'(Grant), 32'h0);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset    = 1'b0;
    Request  = 4'b0000;
    Request0 = 4'b0000;
    tick();
    tick();
    check("rst_grant", 32'(Grant), 32'h0);
    check("rst_done", 32'(Done), 32'h0);
    check("rst_id", 32'(GrantId), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst0_busy", 32'(Busy0), 32'h0);

    // Single request.
    Reset   = 1'b1;
    Request = 4'b0001;
    tick();
    serve(4'b0001, 2'd0, "single");
    Request = 4'b0000;
    tick();
    check("single_stay_idle", 32'(Busy), 32'h0);

    // Contention from Ptr=0: 0,1,2,3,0 with all requests held.
    do_reset();
    Request = 4'b1111;
    tick();
    serve(4'b0001, 2'd0, "rr0");
    tick();
    serve(4'b0010, 2'd1, "rr1");
    tick();
    serve(4'b0100, 2'd2, "rr2");
    tick();
    serve(4'b1000, 2'd3, "rr3");
    tick();
    serve(4'b0001, 2'd0, "rr4");

    // Wrap-around: serve 3, then 1001 goes to 0.
    Request = 4'b1000;
    tick();
    serve(4'b1000, 2'd3, "wrap3");
    Request = 4'b1001;
    tick();
    serve(4'b0001, 2'd0, "wrap0");

    // Winner fixed once granted: ptr=1, 0001 wins, then others rise.
    Request = 4'b0001;
    tick();
    check("hold_id", 32'(GrantId), 32'h0);
    Request = 4'b1111;
    tick();
    check("hold_grant", 32'(Grant), 32'h1);
    check("hold_id2", 32'(GrantId), 32'h0);
    Request = 4'b0000;

    // Reset mid-RUN at count=2 on requester 2.
    do_reset();
    Request = 4'b0100;
    tick();
    check("rmid_grant", 32'(Grant), 32'h4);
    tick();
    tick();
    Reset = 1'b0;
    tick();
    check("rmid_grant_off", 32'(Grant), 32'h0);
    check("rmid_busy", 32'(Busy), 32'h0);
    check("rmid_nodone", 32'(Done), 32'h0);
    tick();
    check("rmid_nodone2", 32'(Done), 32'h0);
    Reset   = 1'b1;
    Request = 4'b1001;
    tick();
    serve(4'b0001, 2'd0, "rmid_after");

    // Drop Request[0] at count=1.
    do_reset();
    Request = 4'b0001;
    tick();
    check("abt_grant", 32'(Grant), 32'h1);
    tick();
    Request = 4'b0000;
    tick();
`ifdef DELAY_SCHED_ABORT_EN
    check("abt_grant_off", 32'(Grant), 32'h0);
    check("abt_busy", 32'(Busy), 32'h0);
    check("abt_nodone", 32'(Done), 32'h0);
    tick();
    check("abt_nodone2", 32'(Done), 32'h0);
`else
    check("abt_still_grant", 32'(Grant), 32'h1);
    tick();
    check("abt_still_grant2", 32'(Grant), 32'h1);
    tick();
    check("abt_done", 32'(Done), 32'h1);
    check("abt_grant_off", 32'(Grant), 32'h0);
    tick();
    check("abt_idle", 32'(Busy), 32'h0);
`endif
    // Ptr moved past 0 in both cases.
    Request = 4'b0011;
    tick();
    check("abt_next_id", 32'(GrantId), 32'h1);
    check("abt_next_grant", 32'(Grant), 32'h2);
    Request = 4'b0000;

    // MaxCount=0 instance.
    do_reset();
    Request0 = 4'b0010;
    tick();
    check("mc0_grant", 32'(Grant0), 32'h2);
    check("mc0_nodone", 32'(Done0), 32'h0);
    check("mc0_id", 32'(GrantId0), 32'h1);
    Request0 = 4'b0000;
    tick();
    check("mc0_grant_off", 32'(Grant0), 32'h0);
    check("mc0_done", 32'(Done0), 32'h2);
    tick();
    check("mc0_idle", 32'(Busy0), 32'h0);
    check("mc0_done_off", 32'(Done0), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
